// File: rtl/fp64_mac_pipeline.sv
// Fully pipelined fp64 multiply-accumulate, res = TA*TB + C, one op per clock.
// The product and the sum are each rounded to nearest-even (non-fused); subnormals flush to zero.
module fp64_mac_pipeline #(
  parameter int MUL_LAT = 3,
  parameter int ADD_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [63:0] TA_in,
  input  logic [63:0] TB_in,
  input  logic [63:0] C_in,
  output logic [63:0] res_out,
  output logic        error_flag,
  output logic        load_valid,
  output logic        store_valid
);
  localparam int          STAGES = MUL_LAT + ADD_LAT;
  localparam logic [63:0] QNAN   = 64'h7FF8_0000_0000_0000;

  typedef struct packed {
    logic        err;
    logic [63:0] v;
  } fpx_t;

  // Round a normalised value to nearest-even and pack it; out-of-range results become Inf or +0.
  function automatic fpx_t pack_rne(input logic s, input logic signed [12:0] e_in,
                                    input logic [51:0] f, input logic g, input logic st);
    logic [52:0]        fr;
    logic signed [12:0] e;
    fpx_t               r;
    fr    = {1'b0, f} + 53'(g & (st | f[0]));
    e     = e_in + $signed({12'b0, fr[52]});
    r.err = 1'b0;
    r.v   = {s, e[10:0], fr[51:0]};
    if (e >= 13'sd2047) begin
      r.err = 1'b1;
      r.v   = {s, 11'h7FF, 52'h0};
    end else if (e <= 13'sd0) begin
      r.v = 64'h0;
    end
    return r;
  endfunction

  function automatic fpx_t fmul(input logic [63:0] a, input logic [63:0] b);
    logic               s, za, zb, ia, ib, na, nb, g, st;
    logic [105:0]       p;
    logic [51:0]        f;
    logic signed [12:0] e;
    fpx_t               r;
    s  = a[63] ^ b[63];
    za = a[62:52] == 11'h0;
    zb = b[62:52] == 11'h0;
    ia = (&a[62:52]) && (a[51:0] == 52'h0);
    ib = (&b[62:52]) && (b[51:0] == 52'h0);
    na = (&a[62:52]) && (a[51:0] != 52'h0);
    nb = (&b[62:52]) && (b[51:0] != 52'h0);
    p  = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
    e  = $signed({2'b0, a[62:52]}) + $signed({2'b0, b[62:52]}) - 13'sd1023;
    if (p[105]) begin
      f = p[104:53]; g = p[52]; st = |p[51:0]; e = e + 13'sd1;
    end else begin
      f = p[103:52]; g = p[51]; st = |p[50:0];
    end
    r = pack_rne(s, e, f, g, st);
    if (na || nb || (za && ib) || (zb && ia)) begin
      r.err = 1'b1; r.v = QNAN;
    end else if (ia || ib) begin
      r.err = 1'b1; r.v = {s, 11'h7FF, 52'h0};
    end else if (za || zb) begin
      r.err = 1'b0; r.v = {s, 63'h0};
    end
    return r;
  endfunction

  // Three extra bits below the mantissa act as guard/round/sticky during alignment.
  function automatic fpx_t fadd(input fpx_t p, input logic [63:0] c);
    logic               ci, cn, swap, sb, ss, st;
    logic [10:0]        eb, es, d;
    logic [52:0]        mp, mc, mb, ms;
    logic [55:0]        sm, al, n;
    logic [56:0]        sum;
    logic [5:0]         lz;
    logic signed [12:0] e;
    fpx_t               r;
    ci   = (&c[62:52]) && (c[51:0] == 52'h0);
    cn   = (&c[62:52]) && (c[51:0] != 52'h0);
    mp   = (p.v[62:52] == 11'h0) ? 53'h0 : {1'b1, p.v[51:0]};
    mc   = (c[62:52] == 11'h0) ? 53'h0 : {1'b1, c[51:0]};
    swap = {c[62:52], mc} > {p.v[62:52], mp};
    sb   = swap ? c[63] : p.v[63];
    ss   = swap ? p.v[63] : c[63];
    eb   = swap ? c[62:52] : p.v[62:52];
    es   = swap ? p.v[62:52] : c[62:52];
    mb   = swap ? mc : mp;
    ms   = swap ? mp : mc;
    d    = eb - es;
    sm   = {ms, 3'b000};
    if (d >= 11'd56) begin
      al = 56'h0; st = |ms;
    end else begin
      al = sm >> d; st = |(sm << (11'd56 - d));
    end
    al[0] = al[0] | st;
    sum = (sb == ss) ? {1'b0, mb, 3'b000} + {1'b0, al} : {1'b0, mb, 3'b000} - {1'b0, al};
    e   = $signed({2'b0, eb});
    lz  = 6'd0;
    for (int i = 0; i < 56; i++) if (sum[i]) lz = 6'(55 - i);
    if (sum[56]) begin
      n = {sum[56:2], sum[1] | sum[0]}; e = e + 13'sd1;
    end else begin
      n = sum[55:0] << lz; e = e - $signed({7'b0, lz});
    end
    r = pack_rne(sb, e, n[54:3], n[2], n[1] | n[0]);
    if (!n[55]) begin
      r.err = 1'b0; r.v = 64'h0;
    end
    if (cn || (p.err && p.v[51])) begin
      r.err = 1'b1; r.v = QNAN;
    end else if (p.err) begin
      r = p;
    end else if (ci) begin
      r.err = 1'b1; r.v = {c[63], 11'h7FF, 52'h0};
    end
    return r;
  endfunction

  logic [STAGES:1]           vld_pipe_q;
  logic [63:0]               ta_q, tb_q, res_q;
  logic                      err_q;
  fpx_t [MUL_LAT-1:1]        mul_q;
  fpx_t [ADD_LAT-1:1]        add_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      res_q      <= 64'h0;
      err_q      <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], valid_in};
      err_q      <= vld_pipe_q[STAGES-1] & add_q[ADD_LAT-1].err;
      if (vld_pipe_q[STAGES-1]) res_q <= add_q[ADD_LAT-1].v;
    end
  end

  // Datapath carries no reset; each arithmetic block is followed by plain stages for retiming.
  always_ff @(posedge clk) begin
    ta_q     <= TA_in;
    tb_q     <= TB_in;
    mul_q[1] <= fmul(ta_q, tb_q);
    for (int k = 2; k < MUL_LAT; k++) mul_q[k] <= mul_q[k-1];
    add_q[1] <= fadd(mul_q[MUL_LAT-1], C_in);
    for (int k = 2; k < ADD_LAT; k++) add_q[k] <= add_q[k-1];
  end

  assign res_out     = res_q;
  assign error_flag  = err_q;
  assign load_valid  = vld_pipe_q[MUL_LAT];
  assign store_valid = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_fp64_mac_pipeline.sv
// Directed bench for fp64_mac_pipeline: timing, rounding, exceptions, streaming and reset.
module tb_fp64_mac_pipeline;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [63:0] TA_in = 64'h0, TB_in = 64'h0, C_in = 64'h0;
  logic [63:0] res_out;
  logic        error_flag, load_valid, store_valid;
  int          checks = 0;
  int          errors = 0;

  fp64_mac_pipeline #(.MUL_LAT(3), .ADD_LAT(3)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .TA_in(TA_in), .TB_in(TB_in), .C_in(C_in),
    .res_out(res_out), .error_flag(error_flag), .load_valid(load_valid), .store_valid(store_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single isolated op: issue at the current negedge, then watch cycles 1..7.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [63:0] exp_res, input logic exp_err);
    valid_in = 1'b1; TA_in = a; TB_in = b; C_in = c;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      valid_in = 1'b0;
      chk($sformatf("%s.load@%0d", tag, k), load_valid, 64'(k == 3));
      chk($sformatf("%s.store@%0d", tag, k), store_valid, 64'(k == 6));
      if (k >= 6) chk($sformatf("%s.res@%0d", tag, k), res_out, exp_res);
      if (k == 6) chk($sformatf("%s.err", tag), error_flag, 64'(exp_err));
      if (k == 7) chk($sformatf("%s.err_idle", tag), error_flag, 64'h0);
    end
  endtask

  logic [63:0] ta5 [6] = '{64'h3FF0000000000001, 64'h3FF0000000000000, 64'h3FF8000000000000,
                           64'h4008000000000000, 64'h3FE0000000000000, 64'hC010000000000000};
  logic [63:0] tb5 [6] = '{64'h3FF0000000000001, 64'h3FF0000000000000, 64'hC000000000000000,
                           64'h4008000000000000, 64'h3FD0000000000000, 64'h3FE8000000000000};
  logic [63:0] c5  [6] = '{64'h0000000000000000, 64'h3CA0000000000000, 64'h4024000000000000,
                           64'hC023000000000000, 64'h3FC0000000000000, 64'h3FF0000000000000};
  logic [63:0] r5  [6] = '{64'h3FF0000000000002, 64'h3FF0000000000000, 64'h401C000000000000,
                           64'hBFE0000000000000, 64'h3FD0000000000000, 64'hC000000000000000};

  initial begin
    rst = 1'b1;
    @(negedge clk);
    chk("reset.res", res_out, 64'h0);
    chk("reset.err", error_flag, 64'h0);
    chk("reset.load", load_valid, 64'h0);
    chk("reset.store", store_valid, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op("t1", 64'h4025000000000000, 64'h4003800000000000, 64'h4003800000000000, 64'h403C080000000000, 1'b0);
    run_op("t2_zero", 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
    run_op("t3_cancel", 64'h4000000000000000, 64'h3FF8000000000000, 64'hC008000000000000, 64'h0, 1'b0);
    run_op("t4_ovf", 64'h7FE0000000000000, 64'h7FE0000000000000, 64'h0, 64'h7FF0000000000000, 1'b1);
    run_op("t4_nan", 64'h7FF8000000000000, 64'h3FF0000000000000, 64'h0, 64'h7FF8000000000000, 1'b1);
    run_op("zero_inf", 64'h0, 64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF8000000000000, 1'b1);
    run_op("neg_ovf", 64'hFFE0000000000000, 64'h7FE0000000000000, 64'h0, 64'hFFF0000000000000, 1'b1);
    run_op("c_ninf", 64'h3FF0000000000000, 64'h3FF0000000000000, 64'hFFF0000000000000, 64'hFFF0000000000000, 1'b1);
    run_op("sum_ovf", 64'h7FE0000000000000, 64'h3FF8000000000000, 64'h7FE0000000000000, 64'h7FF0000000000000, 1'b1);
    run_op("subn_in", 64'h0000000000000001, 64'h4000000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0);
    run_op("uflow", 64'h9A70000000000000, 64'h1A70000000000000, 64'h0, 64'h0, 1'b0);

    // Six back-to-back ops; C for op j is presented in cycle j+3.
    for (int t = 0; t < 12; t++) begin
      valid_in = (t < 6);
      if (t < 6) begin
        TA_in = ta5[t]; TB_in = tb5[t];
      end
      if (t >= 3 && t < 9) C_in = c5[t-3];
      @(negedge clk);
      chk($sformatf("t5.load@%0d", t + 1), load_valid, 64'((t + 1 >= 3) && (t + 1 <= 8)));
      chk($sformatf("t5.store@%0d", t + 1), store_valid, 64'((t + 1 >= 6) && (t + 1 <= 11)));
      if (t + 1 >= 6 && t + 1 <= 11) begin
        chk($sformatf("t5.res%0d", t - 5), res_out, r5[t-5]);
        chk($sformatf("t5.err%0d", t - 5), error_flag, 64'h0);
      end
    end
    valid_in = 1'b0;
    chk("t5.res_held", res_out, r5[5]);

    // Reset two cycles into an op: outputs clear asynchronously and the op never completes.
    valid_in = 1'b1; TA_in = 64'h4025000000000000; TB_in = 64'h4003800000000000; C_in = 64'h4003800000000000;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6.async_res", res_out, 64'h0);
    chk("t6.async_err", error_flag, 64'h0);
    chk("t6.async_store", store_valid, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("t6.no_store@%0d", k), store_valid, 64'h0);
      chk($sformatf("t6.no_load@%0d", k), load_valid, 64'h0);
    end
    run_op("t6_after", 64'h4025000000000000, 64'h4003800000000000, 64'h4003800000000000, 64'h403C080000000000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
